// File: rtl/axis_pad_arbiter_if.sv
// AXI-Stream bundle (valid/ready/data/last) shared by the arbiter's sources and sink.
// Latency: none, wires only.
// Backpressure: tready flows from the slave side back to the master side.
interface axis_pad_arbiter_if #(
   parameter int DW = 64
);
   logic          tvalid;
   logic          tready;
   logic [DW-1:0] tdata;
   logic          tlast;

   modport master (output tvalid, output tdata, output tlast, input tready);
   modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/axis_pad_arbiter.sv
// Two-source packet-granular round-robin AXI-Stream arbiter feeding the frame padding stage.
// Latency: grant one cycle after tvalid is seen idle; zero-latency datapath while granted; one idle bubble between packets.
// Backpressure: m_axis tready passes straight to the granted source; the other source sees tready low.
module axis_pad_arbiter #(
   parameter int DW = 64,
   parameter int CW = 32
) (
   input  logic              s_axis_aclk,
   input  logic              s_axis_aresetn,
   input  logic [CW-1:0]     frame_num_max_0,
   input  logic [CW-1:0]     frame_num_max_1,
   axis_pad_arbiter_if.slave  s0,
   axis_pad_arbiter_if.slave  s1,
   axis_pad_arbiter_if.master m,
   output logic [CW-1:0]     oFrameNumMax,
   output logic [1:0]        grant,
   output logic [CW-1:0]     pkt_cnt,
   output logic              err_overlong,
   input  logic              err_clr
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_GNT0 = 2'd1;
   localparam logic [1:0] ST_GNT1 = 2'd2;

   logic [1:0]    state_q, state_d;
   logic          last_gnt_q, last_gnt_d;   // 1: source 1 finished the most recent packet
   logic [CW-1:0] frame_max_q, frame_max_d;
   logic [CW-1:0] beat_cnt_q, beat_cnt_d;
   logic [CW-1:0] pkt_cnt_q, pkt_cnt_d;
   logic          err_q, err_d;

   logic [DW-1:0] sel_tdata;
   logic          sel_tvalid;
   logic          sel_tlast;
   logic          m_hs;
   logic [CW:0]   beat_num;                 // 1-based count including the current beat
   logic [CW-1:0] beat_inc;
   logic          overlong;

   // Route the granted source straight to the sink; everything is quiet while idle.
   always_comb begin
      sel_tdata  = '0;
      sel_tvalid = 1'b0;
      sel_tlast  = 1'b0;
      s0.tready  = 1'b0;
      s1.tready  = 1'b0;
      case (state_q)
         ST_GNT0: begin
            sel_tdata  = s0.tdata;
            sel_tvalid = s0.tvalid;
            sel_tlast  = s0.tlast;
            s0.tready  = m.tready;
         end
         ST_GNT1: begin
            sel_tdata  = s1.tdata;
            sel_tvalid = s1.tvalid;
            sel_tlast  = s1.tlast;
            s1.tready  = m.tready;
         end
         default: ;
      endcase
      m.tdata  = sel_tdata;
      m.tvalid = sel_tvalid;
      m.tlast  = sel_tlast;
   end

   assign m_hs     = sel_tvalid & m.tready;
   assign beat_num = {1'b0, beat_cnt_q} + {{CW{1'b0}}, 1'b1};
   assign beat_inc = (&beat_cnt_q) ? beat_cnt_q : beat_num[CW-1:0];
   assign overlong = m_hs && (frame_max_q != '0) && (beat_num > {1'b0, frame_max_q});

   // Arbitration, per-packet config capture, beat/packet counting and sticky overlong flag.
   always_comb begin
      state_d     = state_q;
      last_gnt_d  = last_gnt_q;
      frame_max_d = frame_max_q;
      beat_cnt_d  = beat_cnt_q;
      pkt_cnt_d   = pkt_cnt_q;
      case (state_q)
         ST_IDLE: begin
            // On a tie the source that did not go last wins; a lone requester always wins.
            if (s0.tvalid && (!s1.tvalid || last_gnt_q)) begin
               state_d     = ST_GNT0;
               frame_max_d = frame_num_max_0;
               beat_cnt_d  = '0;
            end else if (s1.tvalid) begin
               state_d     = ST_GNT1;
               frame_max_d = frame_num_max_1;
               beat_cnt_d  = '0;
            end
         end
         ST_GNT0, ST_GNT1: begin
            if (m_hs) begin
               beat_cnt_d = beat_inc;
               if (sel_tlast) begin
                  state_d    = ST_IDLE;
                  last_gnt_d = (state_q == ST_GNT1);
                  pkt_cnt_d  = pkt_cnt_q + {{(CW-1){1'b0}}, 1'b1};
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Clear wins over a same-cycle set.
      err_d = err_clr ? 1'b0 : (err_q | overlong);
   end

   // State registers with synchronous active-low reset; a reset abandons any packet in flight.
   always_ff @(posedge s_axis_aclk) begin
      if (!s_axis_aresetn) begin
         state_q     <= ST_IDLE;
         last_gnt_q  <= 1'b1;
         frame_max_q <= '0;
         beat_cnt_q  <= '0;
         pkt_cnt_q   <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_gnt_q  <= last_gnt_d;
         frame_max_q <= frame_max_d;
         beat_cnt_q  <= beat_cnt_d;
         pkt_cnt_q   <= pkt_cnt_d;
         err_q       <= err_d;
      end
   end

   assign grant        = {state_q == ST_GNT1, state_q == ST_GNT0};
   assign oFrameNumMax = frame_max_q;
   assign pkt_cnt      = pkt_cnt_q;
   assign err_overlong = err_q;

endmodule

// File: tb/tb_axis_pad_arbiter.sv
// Self-checking bench for axis_pad_arbiter: directed scenarios plus randomized traffic.
// Latency: a behavioural model predicts every cycle's outputs from the arbitration rules.
// Backpressure: sink tready is driven always-on, toggling or random depending on the phase.
module tb_axis_pad_arbiter;
   localparam int DW = 64;
   localparam int CW = 32;

   logic          s_axis_aclk = 1'b0;
   logic          s_axis_aresetn;
   logic [CW-1:0] frame_num_max_0, frame_num_max_1;
   logic [CW-1:0] oFrameNumMax, pkt_cnt;
   logic [1:0]    grant;
   logic          err_overlong, err_clr;

   axis_pad_arbiter_if #(.DW(DW)) s0_if ();
   axis_pad_arbiter_if #(.DW(DW)) s1_if ();
   axis_pad_arbiter_if #(.DW(DW)) m_if ();

   axis_pad_arbiter #(.DW(DW), .CW(CW)) dut (
      .s_axis_aclk     (s_axis_aclk),
      .s_axis_aresetn  (s_axis_aresetn),
      .frame_num_max_0 (frame_num_max_0),
      .frame_num_max_1 (frame_num_max_1),
      .s0              (s0_if),
      .s1              (s1_if),
      .m               (m_if),
      .oFrameNumMax    (oFrameNumMax),
      .grant           (grant),
      .pkt_cnt         (pkt_cnt),
      .err_overlong    (err_overlong),
      .err_clr         (err_clr)
   );

   always #5 s_axis_aclk = ~s_axis_aclk;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Source drivers
   int  len [2];
   int  idx [2];
   int  pid [2];
   int  gap [2];
   int  budget [2];
   bit  en [2];
   bit  vld [2];
   int  len_min = 1, len_max = 1;
   int  rdy_mode = 0;           // 0 always ready, 1 toggle, 2 random
   bit  simple_data = 0;
   bit  cfg_bump = 0;
   bit  rnd_misc = 0;

   // Observed traffic
   int          m_n = 0;
   int          src_n [2];
   logic [63:0] m_log [$];
   logic [1:0]  g_log [$];
   logic [31:0] f_log [$];
   logic [1:0]  prev_grant = 2'b00;

   // Reference model: who owns the sink, who won last, latched config, counters
   int          own;
   int          last_win;
   logic [31:0] mfmax, mbeats, mpkts;
   bit          merr;

   function automatic void model_reset();
      own = -1; last_win = 1; mfmax = 0; mbeats = 0; mpkts = 0; merr = 0;
   endfunction

   function automatic int new_len();
      return int'($urandom_range(len_max, len_min));
   endfunction

   function automatic logic [63:0] mk_data(input int s);
      if (simple_data) return 64'hA + 64'(idx[s]);
      return {8'(s), 24'(pid[s]), 32'(idx[s])};
   endfunction

   task automatic apply_src();
      s0_if.tvalid = vld[0];
      s0_if.tdata  = mk_data(0);
      s0_if.tlast  = vld[0] && (idx[0] == len[0] - 1);
      s1_if.tvalid = vld[1];
      s1_if.tdata  = mk_data(1);
      s1_if.tlast  = vld[1] && (idx[1] == len[1] - 1);
   endtask

   task automatic setup_src(input int s, input int n, input int g);
      en[s] = (n > 0); budget[s] = n; gap[s] = g; idx[s] = 0; pid[s]++;
      len[s] = new_len(); vld[s] = en[s];
      apply_src();
   endtask

   // One clock cycle: entered and left at posedge+1 with inputs already driven.
   task automatic step();
      bit          v [2];
      bit          l [2];
      logic [63:0] d [2];
      bit          mr, h0, h1, mh, hs, set;
      logic [1:0]  eg;
      bit          emv, eml, er0, er1;
      logic [63:0] ed;
      int          w;
      #3;
      v[0] = s0_if.tvalid; v[1] = s1_if.tvalid;
      l[0] = s0_if.tlast;  l[1] = s1_if.tlast;
      d[0] = s0_if.tdata;  d[1] = s1_if.tdata;
      mr   = m_if.tready;
      eg = 2'b00; emv = 0; eml = 0; ed = '0; er0 = 0; er1 = 0;
      if (own >= 0) begin
         eg  = (own == 0) ? 2'b01 : 2'b10;
         emv = v[own]; ed = d[own]; eml = l[own];
         if (own == 0) er0 = mr; else er1 = mr;
      end
      chk("grant",     64'(grant),         64'(eg));
      chk("m_tvalid",  64'(m_if.tvalid),   64'(emv));
      chk("m_tdata",   m_if.tdata,         ed);
      chk("m_tlast",   64'(m_if.tlast),    64'(eml));
      chk("s0_tready", 64'(s0_if.tready),  64'(er0));
      chk("s1_tready", 64'(s1_if.tready),  64'(er1));
      chk("frame_max", 64'(oFrameNumMax),  64'(mfmax));
      chk("pkt_cnt",   64'(pkt_cnt),       64'(mpkts));
      chk("err",       64'(err_overlong),  64'(merr));
      if (prev_grant == 2'b00 && grant != 2'b00) begin
         g_log.push_back(grant);
         f_log.push_back(oFrameNumMax);
      end
      prev_grant = grant;
      h0 = s0_if.tvalid && s0_if.tready;
      h1 = s1_if.tvalid && s1_if.tready;
      mh = m_if.tvalid && m_if.tready;
      if (h0) src_n[0]++;
      if (h1) src_n[1]++;
      if (mh) begin m_n++; m_log.push_back(m_if.tdata); end
      // Model update for the coming edge
      if (!s_axis_aresetn) begin
         model_reset();
      end else begin
         set = 0;
         if (own < 0) begin
            w = -1;
            if (v[0] && v[1]) w = 1 - last_win;
            else if (v[0])    w = 0;
            else if (v[1])    w = 1;
            if (w >= 0) begin
               own = w; mfmax = (w == 0) ? frame_num_max_0 : frame_num_max_1; mbeats = 0;
            end
         end else if (v[own] && mr) begin
            if (mfmax != 0 && (longint'(mbeats) + 1) > longint'(mfmax)) set = 1;
            if (mbeats != 32'hFFFF_FFFF) mbeats = mbeats + 1;
            if (l[own]) begin last_win = own; own = -1; mpkts = mpkts + 1; end
         end
         merr = err_clr ? 1'b0 : (merr | set);
      end
      @(posedge s_axis_aclk);
      #1;
      for (int s = 0; s < 2; s++) begin
         hs = (s == 0) ? h0 : h1;
         if (hs) begin
            idx[s]++;
            if (idx[s] == len[s]) begin
               idx[s] = 0; pid[s]++; len[s] = new_len(); budget[s]--;
               if (budget[s] <= 0) en[s] = 0;
            end
         end
         if (hs || !vld[s]) vld[s] = en[s] && ($urandom_range(99, 0) >= gap[s]);
      end
      if (cfg_bump && h0 && idx[0] == 1) frame_num_max_0 = 8;
      case (rdy_mode)
         0:       m_if.tready = 1'b1;
         1:       m_if.tready = ~m_if.tready;
         default: m_if.tready = 1'($urandom_range(1, 0));
      endcase
      if (rnd_misc) begin
         err_clr = ($urandom_range(19, 0) == 0);
         if ($urandom_range(29, 0) == 0) frame_num_max_0 = $urandom_range(7, 0);
         if ($urandom_range(29, 0) == 0) frame_num_max_1 = $urandom_range(7, 0);
      end else begin
         err_clr = 1'b0;
      end
      apply_src();
   endtask

   task automatic run(input int maxc);
      int c = 0;
      while ((en[0] || en[1] || vld[0] || vld[1] || own >= 0) && c < maxc) begin
         step();
         c++;
      end
      if (c >= maxc) begin
         n_chk++; n_fail++;
         $display("FAIL timeout: traffic did not drain within %0d cycles", c);
      end
      step();
      step();
   endtask

   task automatic quiet_sources();
      for (int s = 0; s < 2; s++) begin en[s] = 0; vld[s] = 0; idx[s] = 0; end
      apply_src();
   endtask

   task automatic do_reset();
      s_axis_aresetn = 1'b0;
      quiet_sources();
      step();
      step();
      s_axis_aresetn = 1'b1;
   endtask

   initial begin
      int m0, s0n, c;
      s_axis_aresetn  = 1'b0;
      frame_num_max_0 = '0;
      frame_num_max_1 = '0;
      err_clr         = 1'b0;
      m_if.tready     = 1'b0;
      src_n[0] = 0; src_n[1] = 0; pid[0] = 0; pid[1] = 0;
      len[0] = 1; len[1] = 1;
      quiet_sources();
      @(posedge s_axis_aclk);
      #1;
      model_reset();
      step();
      s_axis_aresetn = 1'b1;
      chk("rst_grant",   64'(grant),        64'(0));
      chk("rst_fmax",    64'(oFrameNumMax), 64'(0));
      chk("rst_pkt_cnt", 64'(pkt_cnt),      64'(0));
      chk("rst_err",     64'(err_overlong), 64'(0));
      chk("rst_mvalid",  64'(m_if.tvalid),  64'(0));

      // Single source, two beats 0xA/0xB
      len_min = 2; len_max = 2; simple_data = 1; rdy_mode = 0; m_if.tready = 1'b1;
      frame_num_max_0 = 4; m_log.delete(); g_log.delete(); f_log.delete();
      setup_src(0, 1, 0);
      step();
      chk("t1_grant_next", 64'(grant), 64'(2'b01));
      run(50);
      chk("t1_pkt_cnt", 64'(pkt_cnt), 64'(1));
      chk("t1_nbeats",  64'(m_log.size()), 64'(2));
      if (m_log.size() == 2) begin
         chk("t1_beat0", m_log[0], 64'hA);
         chk("t1_beat1", m_log[1], 64'hB);
      end
      if (f_log.size() > 0) chk("t1_fmax", 64'(f_log[0]), 64'(4));
      simple_data = 0;

      // Tie from reset: 0,1,0,1 with alternating config
      do_reset();
      frame_num_max_0 = 5; frame_num_max_1 = 7; len_min = 3; len_max = 3;
      g_log.delete(); f_log.delete();
      setup_src(0, 2, 0);
      setup_src(1, 2, 0);
      run(100);
      chk("t2_ngrants", 64'(g_log.size()), 64'(4));
      if (g_log.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            chk("t2_order", 64'(g_log[i]), (i % 2 == 0) ? 64'd1 : 64'd2);
            chk("t2_fmax",  64'(f_log[i]), (i % 2 == 0) ? 64'd5 : 64'd7);
         end
      end

      // Backpressure toggling with source gaps
      len_min = 5; len_max = 5; rdy_mode = 1;
      m0 = m_n; s0n = src_n[0];
      setup_src(0, 2, 40);
      run(400);
      chk("t3_m_beats",  64'(m_n - m0),         64'(10));
      chk("t3_s0_beats", 64'(src_n[0] - s0n),   64'(10));

      // Config change mid-packet
      rdy_mode = 0; m_if.tready = 1'b1; len_min = 4; len_max = 4;
      frame_num_max_0 = 4; cfg_bump = 1; g_log.delete(); f_log.delete();
      setup_src(0, 2, 0);
      run(100);
      cfg_bump = 0;
      chk("t4_ngrants", 64'(f_log.size()), 64'(2));
      if (f_log.size() == 2) begin
         chk("t4_fmax_first",  64'(f_log[0]), 64'(4));
         chk("t4_fmax_second", 64'(f_log[1]), 64'(8));
      end

      // Overlong: 3 beats against a limit of 2, stickiness, clear, zero limit
      frame_num_max_1 = 2; len_min = 3; len_max = 3;
      setup_src(1, 1, 0);
      run(50);
      chk("t5_err_set", 64'(err_overlong), 64'(1));
      len_min = 1; len_max = 1;
      setup_src(1, 1, 0);
      run(50);
      chk("t5_err_sticky", 64'(err_overlong), 64'(1));
      err_clr = 1'b1;
      step();
      chk("t5_err_clr", 64'(err_overlong), 64'(0));
      frame_num_max_1 = 0; len_min = 3; len_max = 3;
      setup_src(1, 1, 0);
      run(50);
      chk("t5_err_zero_limit", 64'(err_overlong), 64'(0));

      // Reset during beat 2 of an s0 packet
      len_min = 4; len_max = 4; frame_num_max_0 = 6;
      setup_src(0, 1, 0);
      c = 0;
      while (!(vld[0] && idx[0] == 1) && c < 20) begin step(); c++; end
      if (c >= 20) begin
         n_chk++; n_fail++;
         $display("FAIL timeout: beat 2 never presented (%0d cycles)", c);
      end
      s_axis_aresetn = 1'b0;
      step();
      quiet_sources();
      chk("t6_grant",   64'(grant),        64'(0));
      chk("t6_s0_rdy",  64'(s0_if.tready), 64'(0));
      chk("t6_s1_rdy",  64'(s1_if.tready), 64'(0));
      chk("t6_mvalid",  64'(m_if.tvalid),  64'(0));
      chk("t6_pkt_cnt", 64'(pkt_cnt),      64'(0));
      chk("t6_fmax",    64'(oFrameNumMax), 64'(0));
      s_axis_aresetn = 1'b1;
      len_min = 2; len_max = 2; g_log.delete(); f_log.delete();
      setup_src(0, 1, 0);
      setup_src(1, 1, 0);
      run(50);
      if (g_log.size() > 0) chk("t6_first_tie", 64'(g_log[0]), 64'(2'b01));
      else chk("t6_ngrants", 64'(g_log.size()), 64'(2));

      // Randomized traffic, backpressure, config churn and clears
      rnd_misc = 1; rdy_mode = 2; len_min = 1; len_max = 6;
      frame_num_max_0 = 3; frame_num_max_1 = 2;
      m0 = m_n; s0n = src_n[0] + src_n[1];
      setup_src(0, 40, 30);
      setup_src(1, 40, 30);
      run(20000);
      rnd_misc = 0; err_clr = 1'b0;
      chk("t7_beats", 64'(m_n - m0), 64'(src_n[0] + src_n[1] - s0n));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
